// File: rtl/axum_uart_bus_host.sv
// UART-side bus initiator: parses CMD/ADDR/DATA byte frames from the UART
// receive stream, issues one single-word bus transaction per frame and
// returns a status byte (plus 4 read-data bytes on a successful read).
module axum_uart_bus_host #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o
);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] ST_OK      = 8'hA5;
  localparam logic [7:0] ST_BADCMD  = 8'hE0;
  localparam logic [7:0] ST_BUSERR  = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;
  localparam logic [7:0] ST_MISALGN = 8'hE3;
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_STATUS, S_RDATA
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] cnt_q, cnt_d;

  logic rx_fire;
  logic tx_fire;

  // Output decode from registered state only; reset forces every strobe low.
  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    bus_req_o  = 1'b0;
    bus_be_o   = 4'h0;
    busy_o     = 1'b0;
    if (!rst_i) begin
      rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
      tx_valid_o = (state_q == S_STATUS) || (state_q == S_RDATA);
      bus_req_o  = (state_q == S_REQ);
      bus_be_o   = ((state_q == S_REQ) || (state_q == S_WAIT)) ? 4'hF : 4'h0;
      busy_o     = (state_q != S_IDLE);
      if (state_q == S_STATUS) begin
        tx_data_o = status_q;
      end else if (state_q == S_RDATA) begin
        case (idx_q)
          2'd0:    tx_data_o = rdata_q[7:0];
          2'd1:    tx_data_o = rdata_q[15:8];
          2'd2:    tx_data_o = rdata_q[23:16];
          default: tx_data_o = rdata_q[31:24];
        endcase
      end
    end
  end

  assign rx_fire     = rx_valid_i & rx_ready_o;
  assign tx_fire     = tx_valid_o & tx_ready_i;
  assign bus_addr_o  = addr_q;
  assign bus_we_o    = we_q;
  assign bus_wdata_o = wdata_q;

  // Frame parser, bus sequencing and response sequencing.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          idx_d = 2'd0;
          if (rx_data_i == CMD_WRITE) begin
            we_d    = 1'b1;
            state_d = S_ADDR;
          end else if (rx_data_i == CMD_READ) begin
            we_d    = 1'b0;
            state_d = S_ADDR;
          end else begin
            status_d = ST_BADCMD;
            state_d  = S_STATUS;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          // Little-endian shift-in: the first byte lands in [7:0] after four bytes.
          addr_d = {rx_data_i, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (addr_d[1:0] != 2'b00) begin
              status_d = ST_MISALGN;
              state_d  = S_STATUS;
            end else if (we_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          wdata_d = {rx_data_i, wdata_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (bus_rvalid_i) begin
          state_d = S_STATUS;
          if (bus_err_i) begin
            status_d = ST_BUSERR;
          end else begin
            status_d = ST_OK;
            if (!we_q) begin
              rdata_d = bus_rdata_i;
            end
          end
        end else if (cnt_q == TMO_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = S_STATUS;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STATUS: begin
        if (tx_fire) begin
          idx_d   = 2'd0;
          state_d = ((status_q == ST_OK) && !we_q) ? S_RDATA : S_IDLE;
        end
      end
      S_RDATA: begin
        if (tx_fire) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and frame registers; reset clears everything so all outputs read 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      status_q <= 8'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axum_uart_bus_host.sv
// Directed bench for axum_uart_bus_host with expected-byte and
// expected-transaction scoreboards and a small memory-backed bus responder.
module tb_axum_uart_bus_host;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_err_i = 1'b0;
  logic        busy_o;

  axum_uart_bus_host #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  int   ntests = 0;
  int   nfail  = 0;
  logic [7:0] tq[$];
  txn_t bq[$];

  // Responder / environment controls
  int   rsp_delay  = 1;
  logic rsp_err    = 1'b0;
  logic late_pulse = 1'b0;
  logic tx_force   = 1'b1;
  logic tx_rnd     = 1'b0;
  int   exp_wait   = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] defrd(input logic [31:0] a);
    return 32'hC0DE0000 ^ a;
  endfunction

  // Memory-backed responder: answers rsp_delay cycles after the request (0 = silent).
  logic [31:0] mem [logic [31:0]];
  int          cd = 0;
  logic [31:0] cur_addr = 32'h0;
  always @(negedge clk) begin
    bus_rvalid_i = late_pulse;
    bus_err_i    = 1'b0;
    bus_rdata_i  = 32'h5555AAAA;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus_rvalid_i = 1'b1;
        bus_err_i    = rsp_err;
        bus_rdata_i  = mem.exists(cur_addr) ? mem[cur_addr] : defrd(cur_addr);
      end
    end
    if (bus_req_o) begin
      cd       = rsp_delay;
      cur_addr = bus_addr_o;
      if (bus_we_o) mem[bus_addr_o] = bus_wdata_o;
    end
  end

  // UART transmit-side ready generator
  always @(posedge clk) begin
    #1;
    tx_ready_i = tx_rnd ? 1'($urandom_range(0, 1)) : tx_force;
  end

  // Output monitor: scoreboards, bus stability, wait-cycle count, tx stall stability
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  int          wait_cnt = 0;
  logic        in_txn = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h0;
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("tx_stall_valid", 64'(tx_valid_o), 64'd1);
      chk("tx_stall_data", 64'(tx_data_o), 64'(prev_data));
    end
    prev_stall = tx_valid_o && !tx_ready_i;
    prev_data  = tx_data_o;
    if (tx_valid_o && tx_ready_i) begin
      if (tq.size() == 0) chk("tx_unexpected", 64'(tx_data_o), 64'h100);
      else chk("tx_byte", 64'(tx_data_o), 64'(tq.pop_front()));
    end
    if (bus_req_o) begin
      if (bq.size() == 0) begin
        chk("bus_unexpected_req", 64'd1, 64'd0);
      end else begin
        txn_t e;
        e = bq.pop_front();
        chk("bus_addr", 64'(bus_addr_o), 64'(e.addr));
        chk("bus_we", 64'(bus_we_o), 64'(e.we));
        if (e.we) chk("bus_wdata", 64'(bus_wdata_o), 64'(e.wdata));
        chk("bus_be", 64'(bus_be_o), 64'hF);
      end
      cap_addr = bus_addr_o; cap_we = bus_we_o; cap_wdata = bus_wdata_o;
      wait_cnt = 0;
      in_txn   = 1'b1;
    end else if (in_txn && bus_be_o == 4'hF) begin
      wait_cnt++;
      chk("wait_addr_stable", 64'(bus_addr_o), 64'(cap_addr));
      chk("wait_we_stable", 64'(bus_we_o), 64'(cap_we));
      chk("wait_wdata_stable", 64'(bus_wdata_o), 64'(cap_wdata));
    end else if (in_txn) begin
      in_txn = 1'b0;
      if (exp_wait >= 0) chk("wait_cycles", 64'(wait_cnt), 64'(exp_wait));
      exp_wait = -1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = rx_ready_o;
      @(posedge clk); #1;
      if (ok) break;
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic we, input logic [31:0] a, input logic [31:0] d, input int maxgap);
    bq.push_back('{addr: a, we: we, wdata: d});
    send_byte(we ? 8'h01 : 8'h02, $urandom_range(0, maxgap));
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], $urandom_range(0, maxgap));
    if (we) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], $urandom_range(0, maxgap));
    chk("req_latency", 64'(bus_req_o), 64'd1);
  endtask

  task automatic push_rd(input logic [31:0] d);
    tq.push_back(8'hA5);
    for (int i = 0; i < 4; i++) tq.push_back(d[8*i +: 8]);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (tq.size() == 0 && !busy_o) begin done = 1'b1; break; end
    end
    @(posedge clk); #1;
    chk("idle_timeout", 64'(done), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready_o), 64'd0);
    chk({tag, "_tx_valid"}, 64'(tx_valid_o), 64'd0);
    chk({tag, "_tx_data"}, 64'(tx_data_o), 64'd0);
    chk({tag, "_req"}, 64'(bus_req_o), 64'd0);
    chk({tag, "_addr"}, 64'(bus_addr_o), 64'd0);
    chk({tag, "_we"}, 64'(bus_we_o), 64'd0);
    chk({tag, "_be"}, 64'(bus_be_o), 64'd0);
    chk({tag, "_wdata"}, 64'(bus_wdata_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("idle_rx_ready", 64'(rx_ready_o), 64'd1);

    // Write then read-back
    exp_wait = 1;
    tq.push_back(8'hA5);
    send_frame(1'b1, 32'h20000010, 32'hDEADBEEF, 0);
    wait_idle();
    exp_wait = 1;
    push_rd(32'hDEADBEEF);
    send_frame(1'b0, 32'h20000010, 32'h0, 0);
    wait_idle();

    // Bus error on read: status only
    rsp_err = 1'b1; exp_wait = 1;
    tq.push_back(8'hE1);
    send_frame(1'b0, 32'h20000010, 32'h0, 0);
    wait_idle();
    chk("err_busy", 64'(busy_o), 64'd0);
    rsp_err = 1'b0;

    // Timeout with a silent responder, then response exactly in the expiry cycle
    rsp_delay = 0; exp_wait = 8;
    tq.push_back(8'hE2);
    send_frame(1'b0, 32'h00000030, 32'h0, 0);
    wait_idle();
    rsp_delay = 8; exp_wait = 8;
    push_rd(defrd(32'h00000030));
    send_frame(1'b0, 32'h00000030, 32'h0, 0);
    wait_idle();
    rsp_delay = 1;

    // Unknown command and misaligned address
    tq.push_back(8'hE0);
    send_byte(8'h7F, 0);
    wait_idle();
    tq.push_back(8'hE3);
    send_byte(8'h02, 0); send_byte(8'h13, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_idle();

    // Byte arriving while the status byte is stalled must not be consumed
    tx_force = 1'b0;
    @(posedge clk); #1;
    tq.push_back(8'hE0);
    tq.push_back(8'hE0);
    send_byte(8'h7F, 0);
    rx_data = 8'h5A; rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_rx_ready", 64'(rx_ready_o), 64'd0);
      chk("stall_tx_data", 64'(tx_data_o), 64'hE0);
    end
    @(posedge clk); #1;
    tx_force = 1'b1;
    send_byte(8'h5A, 0);
    wait_idle();

    // Random gaps on both sides
    tx_rnd = 1'b1;
    exp_wait = 1;
    tq.push_back(8'hA5);
    send_frame(1'b1, 32'h00000400, 32'h12345678, 3);
    wait_idle();
    exp_wait = 1;
    push_rd(32'h12345678);
    send_frame(1'b0, 32'h00000400, 32'h0, 3);
    wait_idle();
    tx_rnd = 1'b0;

    // Reset mid-frame, late response ignored, fresh frame completes
    send_byte(8'h02, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    rst = 1'b0;
    late_pulse = 1'b1;
    @(posedge clk); #1;
    late_pulse = 1'b0;
    @(posedge clk); #1;
    chk("late_rvalid_busy", 64'(busy_o), 64'd0);
    chk("late_rvalid_tx", 64'(tx_valid_o), 64'd0);
    chk("post_reset_rx_ready", 64'(rx_ready_o), 64'd1);
    exp_wait = 1;
    push_rd(32'hDEADBEEF);
    send_frame(1'b0, 32'h20000010, 32'h0, 0);
    wait_idle();

    chk("tx_queue_empty", 64'(tq.size()), 64'd0);
    chk("bus_queue_empty", 64'(bq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/axum_uart_bus_host.md
Name: axum_uart_bus_host

Overview:
- UART-side bus initiator (debug/loader bridge): consumes a byte stream from the UART receive path, parses read/write command frames, issues single-word transactions on the core data bus as initiator, and returns status/data bytes to the UART transmit path.
- Drives the same req/addr/we/be/wdata to rvalid/rdata/err bus protocol that axum peripherals respond to, from the opposite end: it is the requester, not the responder.
- Sits between the UART byte FIFOs and a bus crossbar initiator port.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for rvalid_i after req_o before aborting; range 1..65535.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  rx_data_i holds a valid byte
- rx_ready_o  output  1  byte accepted when rx_valid_i & rx_ready_o
- tx_data_o  output  8  byte to transmit
- tx_valid_o  output  1  tx_data_o is valid
- tx_ready_i  input  1  byte taken when tx_valid_o & tx_ready_i
- bus_req_o  output  1  one-cycle request strobe
- bus_addr_o  output  32  word address
- bus_we_o  output  1  1 = write
- bus_be_o  output  4  byte enables, always 4'hF
- bus_wdata_o  output  32  write data
- bus_rvalid_i  input  1  response valid
- bus_rdata_i  input  32  read data, valid with bus_rvalid_i
- bus_err_i  input  1  bus error, valid with bus_rvalid_i
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high. Reset forces IDLE, clears counters and partial frames, and drives all outputs to 0, including bus_be_o. Reset mid-transaction drops the frame; any later bus_rvalid_i is ignored in IDLE.
- Frame format: CMD byte, then ADDR as 4 bytes little-endian. If CMD = 0x01 (write), DATA follows as 4 bytes little-endian. CMD = 0x02 is a read.
- Response format: one status byte. A successful read appends 4 data bytes, little-endian.
- Status codes:
  - 0xA5 OK
  - 0xE0 unknown CMD
  - 0xE1 bus_err_i
  - 0xE2 timeout
  - 0xE3 misaligned address (addr[1:0] != 0)
- State machine:
  - IDLE: accept CMD. 0x01 or 0x02 -> ADDR. Any other value -> STATUS with 0xE0.
  - ADDR: accept 4 bytes; byte index 0 is addr[7:0]. After byte 3: misaligned -> STATUS with 0xE3 (no bus access); write -> DATA; read -> REQ.
  - DATA: accept 4 bytes into wdata, then -> REQ.
  - REQ: bus_req_o = 1 for exactly one cycle; timeout counter loaded with 0; -> WAIT.
  - WAIT: counter increments each cycle.
    - bus_rvalid_i with bus_err_i -> STATUS with 0xE1.
    - bus_rvalid_i without error -> STATUS with 0xA5, latching bus_rdata_i on reads.
    - Counter reaches TIMEOUT_CYCLES with no rvalid -> STATUS with 0xE2.
    - bus_rvalid_i in the expiry cycle wins over timeout.
  - STATUS: present the status byte. On handshake: successful read -> RDATA, otherwise -> IDLE.
  - RDATA: 4 bytes, rdata[7:0] first, then -> IDLE.
- Bus rules:
  - bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o are registered and stable from REQ until leaving WAIT. bus_be_o = 4'hF during REQ/WAIT, 0 otherwise.
  - A response is expected no earlier than the cycle after bus_req_o.
  - bus_rvalid_i outside WAIT is ignored.
  - At most one outstanding transaction.
  - bus_rdata_i is ignored on writes and on error.
- Byte handshakes:
  - rx_ready_o = 1 only in IDLE/ADDR/DATA, registered-state-decoded with no combinational path from rx_valid_i.
  - tx_valid_o = 1 only in STATUS/RDATA. tx_data_o stays stable while tx_valid_o & !tx_ready_i.
  - A late tx_ready_i stalls indefinitely; there is no tx timeout.
- Throughput: one byte per cycle on each side when the partner is always ready. Minimum latency from the last frame byte to bus_req_o is 1 cycle.

Test Plan:
- Write then read-back: rx 01 10 00 00 20 EF BE AD DE -> bus_req_o pulse with addr 0x20000010, we=1, be=F, wdata 0xDEADBEEF. Responder rvalid 1 cycle later -> tx A5. Then rx 02 10 00 00 20, rdata 0xDEADBEEF -> tx A5 EF BE AD DE.
- Bus error: read with rvalid & err=1 -> tx E1 only. No data bytes; back in IDLE, busy_o=0.
- Timeout: TIMEOUT_CYCLES=8, responder silent -> tx E2 after 8 WAIT cycles. Variant with rvalid exactly at cycle 8 -> tx A5.
- Protocol errors:
  - rx 7F -> tx E0.
  - rx 02 13 00 00 00 -> tx E3 with no bus_req_o.
  - rx 5A arriving while tx_valid_o=1 and tx_ready_i=0 -> rx_ready_o=0, byte not consumed.
- Backpressure/stability: random rx_valid_i and tx_ready_i gaps -> identical bus transactions and response bytes; tx_data_o unchanged while stalled.
- Reset mid-op: assert rst_i after 3 ADDR bytes -> next cycle all outputs 0, state IDLE; late rvalid ignored; a fresh full frame completes correctly.
